// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, with a stall watchdog.
// Ports: clk, rst (async active-low); m_* master bundles (slice i = master i);
//        m_datrd/m_ack/m_err/m_gnt back to masters; s_* slave-side request/response.
module wishbone_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int SEL_WIDTH   = DAT_WIDTH / 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_datwr,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS-1:0]           m_stb,
    input  logic [NUM_MASTERS-1:0]           m_cyc,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
    output logic [DAT_WIDTH-1:0]             m_datrd,
    output logic [NUM_MASTERS-1:0]           m_ack,
    output logic [NUM_MASTERS-1:0]           m_err,
    output logic [NUM_MASTERS-1:0]           m_gnt,
    output logic [ADR_WIDTH-1:0]             s_adr,
    output logic [DAT_WIDTH-1:0]             s_datwr,
    output logic                             s_we,
    output logic                             s_stb,
    output logic                             s_cyc,
    output logic [SEL_WIDTH-1:0]             s_sel,
    input  logic [DAT_WIDTH-1:0]             s_datrd,
    input  logic                             s_ack
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          g_q, g_d;
    logic [IW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic          busy;
    logic          cyc_g;
    logic          stb_g;
    logic          stall;
    logic          tmo;
    logic          found;
    logic [IW-1:0] pick;
    int            cand;

    assign busy  = (state_q == BUSY);
    assign cyc_g = m_cyc[g_q];
    assign stb_g = m_stb[g_q];
    assign stall = stb_g & ~s_ack;
    // An ack in the same cycle as the last stall cycle suppresses the abort.
    assign tmo   = (TIMEOUT != 0) && busy && cyc_g && stall
                   && (cnt_q == CNT_LAST);

    // Walk candidates from farthest to nearest so the master right after
    // last_q overwrites any later match.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = (int'(last_q) + k) % NUM_MASTERS;
            if (m_cyc[cand]) begin
                pick  = IW'(cand);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    g_d         = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    last_d  = g_q;
                    gnt_d   = '0;
                end else if (tmo) begin
                    state_d = ABORT;
                end else if (stall) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ABORT: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    last_d  = g_q;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IDX_LAST;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_gnt   = gnt_q;
    assign m_datrd = s_datrd;
    assign s_cyc   = busy & cyc_g;
    assign s_stb   = busy & stb_g;
    assign s_we    = m_we[g_q];
    assign s_adr   = m_adr[g_q*ADR_WIDTH +: ADR_WIDTH];
    assign s_datwr = m_datwr[g_q*DAT_WIDTH +: DAT_WIDTH];
    assign s_sel   = m_sel[g_q*SEL_WIDTH +: SEL_WIDTH];

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (busy) begin
            m_ack[g_q] = s_ack & stb_g;
            m_err[g_q] = tmo;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: random traffic vs. a transaction-level model,
// plus directed arbitration, burst, watchdog and reset scenarios.
module tb_wishbone_arbiter;

    localparam int NA = 4;
    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NA*AW-1:0] a_adr;
    logic [NA*DW-1:0] a_datwr;
    logic [NA-1:0]    a_we, a_stb, a_cyc;
    logic [NA*SW-1:0] a_sel;
    logic [DW-1:0]    a_datrd;
    logic [NA-1:0]    a_ack, a_err, a_gnt;
    logic [AW-1:0]    a_s_adr;
    logic [DW-1:0]    a_s_datwr;
    logic             a_s_we, a_s_stb, a_s_cyc;
    logic [SW-1:0]    a_s_sel;
    logic [DW-1:0]    a_s_datrd;
    logic             a_s_ack;

    logic [NB*AW-1:0] b_adr;
    logic [NB*DW-1:0] b_datwr;
    logic [NB-1:0]    b_we, b_stb, b_cyc;
    logic [NB*SW-1:0] b_sel;
    logic [DW-1:0]    b_datrd;
    logic [NB-1:0]    b_ack, b_err, b_gnt;
    logic [AW-1:0]    b_s_adr;
    logic [DW-1:0]    b_s_datwr;
    logic             b_s_we, b_s_stb, b_s_cyc;
    logic [SW-1:0]    b_s_sel;
    logic [DW-1:0]    b_s_datrd;
    logic             b_s_ack;

    wishbone_arbiter #(.NUM_MASTERS(NA), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst),
        .m_adr(a_adr), .m_datwr(a_datwr), .m_we(a_we),
        .m_stb(a_stb), .m_cyc(a_cyc), .m_sel(a_sel),
        .m_datrd(a_datrd), .m_ack(a_ack), .m_err(a_err), .m_gnt(a_gnt),
        .s_adr(a_s_adr), .s_datwr(a_s_datwr), .s_we(a_s_we),
        .s_stb(a_s_stb), .s_cyc(a_s_cyc), .s_sel(a_s_sel),
        .s_datrd(a_s_datrd), .s_ack(a_s_ack)
    );

    wishbone_arbiter #(.NUM_MASTERS(NB), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst),
        .m_adr(b_adr), .m_datwr(b_datwr), .m_we(b_we),
        .m_stb(b_stb), .m_cyc(b_cyc), .m_sel(b_sel),
        .m_datrd(b_datrd), .m_ack(b_ack), .m_err(b_err), .m_gnt(b_gnt),
        .s_adr(b_s_adr), .s_datwr(b_s_datwr), .s_we(b_s_we),
        .s_stb(b_s_stb), .s_cyc(b_s_cyc), .s_sel(b_s_sel),
        .s_datrd(b_s_datrd), .s_ack(b_s_ack)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model of dut_a: who owns the bus, whether that
    // ownership was aborted, who owned it last, and consecutive stalls.
    int owner   = -1;
    int last    = NA - 1;
    int stalls  = 0;
    bit aborted = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        last    = NA - 1;
        stalls  = 0;
        aborted = 1'b0;
    endtask

    task automatic zero_inputs();
        a_adr = '0; a_datwr = '0; a_we = '0; a_stb = '0;
        a_cyc = '0; a_sel = '0; a_s_datrd = '0; a_s_ack = 1'b0;
        b_adr = '0; b_datwr = '0; b_we = '0; b_stb = '0;
        b_cyc = '0; b_sel = '0; b_s_datrd = '0; b_s_ack = 1'b0;
    endtask

    // One clock: compare dut_a against the model mid-cycle, advance the
    // model with the inputs seen at the edge, return 1 time unit after it.
    task automatic cycle();
        bit         busy;
        bit         tmo;
        int         o;
        logic [NA-1:0] eg, ea, ee;
        @(negedge clk);
        o    = (owner < 0) ? 0 : owner;
        busy = (owner >= 0) && !aborted;
        eg = '0; ea = '0; ee = '0;
        if (owner >= 0) eg[o] = 1'b1;
        if (busy && a_s_ack && a_stb[o]) ea[o] = 1'b1;
        tmo = busy && a_cyc[o] && a_stb[o] && !a_s_ack
              && (stalls == TO - 1);
        if (tmo) ee[o] = 1'b1;
        check("gnt", a_gnt, eg);
        check("ack", a_ack, ea);
        check("err", a_err, ee);
        check("s_cyc", a_s_cyc, busy && a_cyc[o]);
        check("s_stb", a_s_stb, busy && a_stb[o]);
        check("datrd", a_datrd, a_s_datrd);
        if (busy) begin
            check("s_adr", a_s_adr, a_adr[o*AW +: AW]);
            check("s_datwr", a_s_datwr, a_datwr[o*DW +: DW]);
            check("s_we", a_s_we, a_we[o]);
            check("s_sel", a_s_sel, a_sel[o*SW +: SW]);
        end
        if (owner < 0) begin
            for (int k = NA; k >= 1; k--) begin
                if (a_cyc[(last + k) % NA]) owner = (last + k) % NA;
            end
            aborted = 1'b0;
            stalls  = 0;
        end else if (!a_cyc[o]) begin
            last    = o;
            owner   = -1;
            aborted = 1'b0;
            stalls  = 0;
        end else if (aborted) begin
            stalls = 0;
        end else if (tmo) begin
            aborted = 1'b1;
            stalls  = 0;
        end else if (a_stb[o] && !a_s_ack) begin
            stalls++;
        end else begin
            stalls = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_gnt", a_gnt, 0);
        check("rst_ack", a_ack, 0);
        check("rst_err", a_err, 0);
        check("rst_s_cyc", a_s_cyc, 0);
        check("rst_s_stb", a_s_stb, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_b_s_cyc", b_s_cyc, 0);
        zero_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int n0, n1;
    int ack_div;

    initial begin
        zero_inputs();
        do_reset();

        // Two masters requesting together: 0 first, then 1.
        b_cyc = 2'b11; b_stb = 2'b11;
        b_adr = {32'hB111_0001, 32'hB000_0000};
        cycle();
        check("b_first_gnt", b_gnt, 2'b01);
        check("b_first_adr", b_s_adr, 32'hB000_0000);
        b_cyc = 2'b10;
        cycle();
        check("b_release_gnt", b_gnt, 2'b00);
        cycle();
        check("b_second_gnt", b_gnt, 2'b10);
        check("b_second_cyc", b_s_cyc, 1);
        check("b_second_adr", b_s_adr, 32'hB111_0001);
        b_s_ack = 1'b1;
        #1;
        check("b_second_ack", b_ack, 2'b10);

        // All four requesting: grants rotate 0,1,2,3,0.
        do_reset();
        a_cyc = '1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_gnt", a_gnt, 1 << (i % NA));
            a_cyc[i % NA] = 1'b0;
            cycle();
            a_cyc[i % NA] = 1'b1;
        end

        // Four-beat burst by master 1 while master 0 waits.
        do_reset();
        a_cyc = 4'b0010; a_stb = 4'b0010;
        cycle();
        a_cyc = 4'b0011; a_stb = 4'b0011;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            a_s_ack = 1'b1;
            a_adr[AW +: AW] = AW'(32'h100 + i);
            #1;
            n0 += int'(a_ack[0]);
            n1 += int'(a_ack[1]);
            cycle();
        end
        a_s_ack = 1'b0;
        check("burst_acks_m1", n1, 4);
        check("burst_acks_m0", n0, 0);
        check("burst_hold_gnt", a_gnt, 4'b0010);
        a_cyc = 4'b0001;
        cycle();
        check("burst_idle_gnt", a_gnt, 4'b0000);
        cycle();
        check("burst_next_gnt", a_gnt, 4'b0001);

        // Slave never acks: error on the eighth stall cycle, then abort.
        do_reset();
        a_cyc = 4'b0100; a_stb = 4'b0100;
        cycle();
        for (int k = 1; k <= TO; k++) begin
            check("tmo_err", a_err, (k == TO) ? 4'b0100 : 4'b0000);
            check("tmo_s_cyc", a_s_cyc, 1);
            cycle();
        end
        check("abort_s_cyc", a_s_cyc, 0);
        check("abort_err", a_err, 0);
        check("abort_gnt", a_gnt, 4'b0100);
        cycle();
        check("abort_hold_gnt", a_gnt, 4'b0100);
        a_cyc = '0;
        cycle();
        check("abort_idle_gnt", a_gnt, 0);

        // Ack landing on the eighth stall cycle wins over the timeout.
        do_reset();
        a_cyc = 4'b1000; a_stb = 4'b1000;
        cycle();
        for (int k = 1; k < TO; k++) cycle();
        a_s_ack = 1'b1;
        #1;
        check("race_ack", a_ack, 4'b1000);
        check("race_err", a_err, 0);
        cycle();
        a_s_ack = 1'b0;
        #1;
        check("race_busy_cyc", a_s_cyc, 1);
        check("race_busy_gnt", a_gnt, 4'b1000);
        for (int k = 1; k < TO; k++) begin
            check("race_restart_err", a_err, 0);
            cycle();
        end
        check("race_late_err", a_err, 4'b1000);
        a_cyc = '0;
        cycle();
        cycle();

        // Reset in the middle of an acked strobe.
        do_reset();
        a_cyc = 4'b1000; a_stb = 4'b1000; a_s_ack = 1'b1;
        cycle();
        check("pre_rst_ack", a_ack, 4'b1000);
        #2;
        do_reset();
        a_cyc = '1;
        cycle();
        check("post_rst_gnt", a_gnt, 4'b0001);
        a_cyc = '0;
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ack_div = ((c / 500) % 2 == 0) ? 5 : 20;
            for (int m = 0; m < NA; m++) begin
                if ($urandom_range(9) == 0) a_cyc[m] = ~a_cyc[m];
                a_stb[m] = ($urandom_range(4) != 0);
                a_we[m]  = 1'($urandom());
                a_adr[m*AW +: AW]   = $urandom();
                a_datwr[m*DW +: DW] = $urandom();
                a_sel[m*SW +: SW]   = 4'($urandom());
            end
            a_s_ack   = ($urandom_range(ack_div) == 0);
            a_s_datrd = $urandom();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of master ports (1..16).
REQ-002 SHALL have parameter ADR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DAT_WIDTH, default 32: data width.
REQ-004 SHALL have parameter SEL_WIDTH, default DAT_WIDTH/8: byte-select width.
REQ-005 SHALL have parameter TIMEOUT, default 255: stall cycles before abort; 0 disables the watchdog.
REQ-006 SHALL have a single clock and an asynchronous, active-low reset, named as follows:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous active-low reset
  m_adr  in  NUM_MASTERS*ADR_WIDTH  master addresses; slice i belongs to master i
  m_datwr  in  NUM_MASTERS*DAT_WIDTH  master write data
  m_we  in  NUM_MASTERS  master write enables
  m_stb  in  NUM_MASTERS  master strobes
  m_cyc  in  NUM_MASTERS  master cycle requests
  m_sel  in  NUM_MASTERS*SEL_WIDTH  master byte selects
  m_datrd  out  DAT_WIDTH  read data, broadcast to all masters
  m_ack  out  NUM_MASTERS  per-master acknowledge
  m_err  out  NUM_MASTERS  per-master timeout error pulse
  m_gnt  out  NUM_MASTERS  one-hot grant
  s_adr, s_datwr, s_we, s_stb, s_cyc, s_sel  out  widths as above  slave-side request
  s_datrd  in  DAT_WIDTH  slave read data
  s_ack  in  1  slave acknowledge

Function
REQ-007 SHALL implement a three-state FSM: IDLE, BUSY, ABORT.
REQ-008 In IDLE, any m_cyc high SHALL latch a grant index g and move to BUSY on the next edge; m_gnt SHALL be registered and one-hot.
REQ-009 Arbitration SHALL be round-robin: search starts at (last_g+1) mod NUM_MASTERS; last_g resets to NUM_MASTERS-1, so master 0 wins first after reset.
REQ-010 Latency: from m_cyc[i] rising in IDLE to s_cyc high SHALL be exactly 1 cycle.
REQ-011 In BUSY, s_adr/s_datwr/s_we/s_stb/s_cyc/s_sel SHALL be combinationally muxed from master g.
REQ-012 In BUSY, m_ack[g] SHALL equal s_ack & m_stb[g]; all other m_ack bits SHALL be 0.
REQ-013 m_datrd SHALL equal s_datrd at all times.
REQ-014 In IDLE and ABORT, s_cyc and s_stb SHALL be 0, and m_ack SHALL be 0.
REQ-015 The grant SHALL be held while m_cyc[g] is high, including multi-beat bursts; requests from other masters SHALL be ignored until then.
REQ-016 m_cyc[g] low in BUSY SHALL cause a transition to IDLE, set last_g to g, and clear m_gnt on the same edge; re-arbitration then happens in IDLE.
REQ-017 The watchdog counter SHALL increment each BUSY cycle with s_stb=1 and s_ack=0, and SHALL clear on s_ack=1, on s_stb=0, or on leaving BUSY.
REQ-018 When TIMEOUT≠0 and the counter equals TIMEOUT-1 with s_ack still 0, m_err[g] SHALL pulse high for exactly 1 cycle and the FSM SHALL move to ABORT.
REQ-019 If s_ack and the timeout condition coincide, ack SHALL win: no m_err, and the counter clears.
REQ-020 ABORT SHALL hold m_gnt until m_cyc[g] falls, then go to IDLE with last_g=g.
REQ-021 With NUM_MASTERS=1, the block SHALL behave identically, with the grant always index 0.

Reset
REQ-022 With rst low, the FSM SHALL be in IDLE, m_gnt=0, m_ack=0, m_err=0, s_cyc=0, s_stb=0, the counter=0, and last_g=NUM_MASTERS-1, asynchronously.
REQ-023 Reset asserted mid-transfer SHALL drop s_cyc immediately without generating ack or err; after release, arbitration restarts from master 0.

Verification
REQ-024 The bench SHALL cover: NUM_MASTERS=2, m_cyc=2'b11 at the same cycle -> master 0 granted first; after it drops cyc, master 1 is granted 1 cycle later.
REQ-025 The bench SHALL cover: NUM_MASTERS=4 with all masters continuously requesting -> grant order 0,1,2,3,0.
REQ-026 The bench SHALL cover: master 1 issues a 4-beat burst with cyc held and master 0 requesting -> 4 acks to master 1 only; master 0 is granted after master 1 releases.
REQ-027 The bench SHALL cover: TIMEOUT=8, slave never acks -> m_err[g] is high for 1 cycle at the 8th stall cycle, s_cyc=0 in the next cycle, and IDLE follows the master dropping cyc.
REQ-028 The bench SHALL cover: TIMEOUT=8 with s_ack on the 8th stall cycle -> m_ack pulses, no m_err, and the FSM stays in BUSY.
REQ-029 The bench SHALL cover: rst asserted during BUSY with stb high -> all outputs go to their reset values within the same cycle; after release, master 0 has priority.
